// File: rtl/cc_seq_sorter_pkg.sv
// cc_pkg: shared types and width helpers for the sequential CC sorter.
//   cc_state_e : FSM states of the top (IDLE, LOAD, CALC, OUT)
//   cc_ew(w)   : extended sample width (one guard bit for signed/unsigned unification)
//   cc_aw(w)   : signed arithmetic width used by the evaluation datapath
//   OPT_*      : bit positions inside the 3-bit opt field
package cc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } cc_state_e;

  localparam int OPT_SIGNED = 0;
  localparam int OPT_DESC   = 1;
  localparam int OPT_NORM   = 2;

  function automatic int cc_ew(input int w);
    return w + 1;
  endfunction

  function automatic int cc_aw(input int w);
    return 2 * w + 3;
  endfunction

endpackage

// File: rtl/cc_seq_sorter_eval.sv
// cc_eval: combinational normalise-and-evaluate stage of the CC equation pair.
//   s       : ordered samples, EW bits each, two's complement
//   norm_en : subtract the mid-range value (s[0]+s[N-1])/2 from every sample
//   equ     : equation select
//   h0      : product term g0*g1
//   term    : equ=1 -> 3*norm[N-3], equ=0 -> norm[0]+norm[N-1]
// The final i0 = term - h0 and its abs / divide step are left to the caller so
// that a registered design can split the long path across two cycles.
module cc_eval
  import cc_pkg::*;
#(
  parameter  int N  = 6,
  parameter  int W  = 4,
  localparam int EW = cc_ew(W),
  localparam int AW = cc_aw(W)
) (
  input  logic [N-1:0][EW-1:0] s,
  input  logic                 norm_en,
  input  logic                 equ,
  output logic signed [AW-1:0] h0,
  output logic signed [AW-1:0] term
);

  logic signed [EW:0]   sum;
  logic signed [EW:0]   avg;
  logic signed [AW-1:0] norm [N];
  logic signed [AW-1:0] g0;
  logic signed [AW-1:0] g1;

  always_comb begin
    // One extra bit so the sum of the extremes cannot overflow; signed '/'
    // truncates toward zero, which is the required rounding of the midpoint.
    sum = (EW+1)'($signed(s[0])) + (EW+1)'($signed(s[N-1]));
    avg = norm_en ? (EW+1)'(sum / 2) : '0;
    for (int i = 0; i < N; i++) begin
      norm[i] = AW'($signed(s[i])) - AW'(avg);
    end
    g0   = equ ? norm[0]   : norm[1];
    g1   = equ ? norm[N-2] : norm[2];
    h0   = g0 * g1;
    term = equ ? (norm[N-3] + norm[N-3] + norm[N-3]) : (norm[0] + norm[N-1]);
  end

endmodule

// File: rtl/cc_seq_sorter.sv
// cc_seq_sorter: serial insertion sorter followed by the CC equation pair.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   in_valid   : sample strobe; in_data : W-bit sample
//   opt, equ   : job options, taken together with the first sample of a job
//   out_valid  : one-cycle result strobe; out_n : result, zero when not valid
// Handshake: in_valid is a push-only strobe with no back-pressure. A sample is
// consumed on every rising edge where in_valid=1 and the FSM is in IDLE or LOAD;
// samples offered while in CALC or OUT are dropped. out_valid is a single-cycle
// pulse with no ready; the consumer must take out_n in that cycle.
module cc_seq_sorter
  import cc_pkg::*;
#(
  parameter int N = 6,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  input  logic [2:0]     opt,
  input  logic           equ,
  output logic           out_valid,
  output logic [2*W:0]   out_n
);

  localparam int EW = cc_ew(W);
  localparam int AW = cc_aw(W);
  localparam int OW = 2 * W + 1;
  localparam int CW = $clog2(N + 1);

  cc_state_e            state;
  cc_state_e            state_nxt;
  logic [CW-1:0]        count;
  logic [EW-1:0]        a     [N];
  logic [EW-1:0]        a_nxt [N];
  logic [2:0]           opt_q;
  logic                 equ_q;
  logic [2:0]           opt_eff;
  logic                 accept;
  logic                 last;
  logic [EW-1:0]        x;
  logic [N-1:0]         gt;
  logic [N-1:0][EW-1:0] s;
  logic signed [AW-1:0] h0;
  logic signed [AW-1:0] term;
  logic signed [AW-1:0] h0_q;
  logic signed [AW-1:0] term_q;
  logic signed [AW-1:0] i0;
  logic [OW-1:0]        res;

  cc_eval #(.N(N), .W(W)) u_eval (
    .s       (s),
    .norm_en (opt_q[OPT_NORM]),
    .equ     (equ_q),
    .h0      (h0),
    .term    (term)
  );

  always_comb begin
    // The first sample of a job arrives before opt is latched, so it must
    // see the live option bits.
    opt_eff = (state == IDLE) ? opt : opt_q;
    accept  = in_valid && ((state == IDLE) || (state == LOAD));
    last    = (count == CW'(N - 1));
    x       = {opt_eff[OPT_SIGNED] & in_data[W-1], in_data};

    // gt is monotonic over the stored prefix because a[] is kept ascending;
    // strict '>' places a new equal value after the existing ones.
    for (int j = 0; j < N; j++) begin
      gt[j] = (count > CW'(j)) && ($signed(a[j]) > $signed(x));
    end
    a_nxt[0] = (gt[0] || (count == '0)) ? x : a[0];
    for (int j = 1; j < N; j++) begin
      if (gt[j-1])                          a_nxt[j] = a[j-1];
      else if (gt[j] || (count == CW'(j)))  a_nxt[j] = x;
      else                                  a_nxt[j] = a[j];
    end

    for (int i = 0; i < N; i++) begin
      s[i] = opt_q[OPT_DESC] ? a[N-1-i] : a[i];
    end

    i0  = term_q - h0_q;
    res = equ_q ? OW'(i0[AW-1] ? -i0 : i0) : OW'(i0 / 3);

    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)         state_nxt = LOAD;
      LOAD:    if (in_valid && last) state_nxt = CALC;
      CALC:                          state_nxt = OUT;
      OUT:                           state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      for (int j = 0; j < N; j++) a[j] <= '0;
      opt_q     <= '0;
      equ_q     <= 1'b0;
      h0_q      <= '0;
      term_q    <= '0;
      out_valid <= 1'b0;
      out_n     <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && in_valid) begin
        opt_q <= opt;
        equ_q <= equ;
      end
      if (accept) begin
        count <= last ? '0 : count + CW'(1);
        for (int j = 0; j < N; j++) a[j] <= a_nxt[j];
      end
      if (state == CALC) begin
        h0_q   <= h0;
        term_q <= term;
      end
      out_valid <= (state == OUT);
      out_n     <= (state == OUT) ? res : '0;
    end
  end

endmodule
